obi_sram_arbiter: RTL and testbench
===================================

// Module: obi_sram_arbiter
// PURPOSE
// - Shares one single-port OBI SRAM slave among NUM_PORTS OBI masters (cores, DMA, host loader).
// - Round-robin arbitration, one outstanding transaction total; routes rvalid/rdata back to the owner.
// - Sits between the requesters and the behavioural/macro SRAM in the GPGPU local memory subsystem.
// PARAMETERS
// - NUM_PORTS  default 4  number of master ports, >=2
// - ADDR_W     default 32 OBI address width
// - DATA_W     default 32 OBI data width; byte enables are DATA_W/8 bits
// PORTS
// - clk_i       in   1                  clock, rising edge
// - rst_i       in   1                  asynchronous, active-high reset
// - m_req_i     in   NUM_PORTS          per-master request
// - m_we_i      in   NUM_PORTS          per-master write enable
// - m_be_i      in   NUM_PORTS*DATA_W/8 per-master byte enables, port p at [p*BE_W +: BE_W]
// - m_addr_i    in   NUM_PORTS*ADDR_W   per-master byte address
// - m_wdata_i   in   NUM_PORTS*DATA_W   per-master write data
// - m_gnt_o     out  NUM_PORTS          per-master grant, one-hot or zero
// - m_rvalid_o  out  NUM_PORTS          per-master response valid, one-hot or zero
// - m_rdata_o   out  NUM_PORTS*DATA_W   per-master read data; zero on non-owner lanes
// - s_req_o     out  1                  request to SRAM
// - s_we_o      out  1                  write enable to SRAM
// - s_be_o      out  DATA_W/8           byte enables to SRAM
// - s_addr_o    out  ADDR_W             address to SRAM
// - s_wdata_o   out  DATA_W             write data to SRAM
// - s_gnt_i     in   1                  SRAM grant, combinational from s_req_o
// - s_rvalid_i  in   1                  SRAM response valid; one per granted request, reads and writes
// - s_rdata_i   in   DATA_W             SRAM read data
// BEHAVIOUR
// - States: IDLE, WAIT_RSP. Registers: state, owner (log2 NUM_PORTS), rr_ptr (last granted port).
// - Reset: state=IDLE, owner=0, rr_ptr=NUM_PORTS-1 so port 0 has first priority.
// - Reset: all outputs 0 while in reset.
// - IDLE:
//   - winner = first requesting port searching rr_ptr+1, rr_ptr+2, ... with modulo NUM_PORTS wrap.
//   - If any request is pending, drive s_req_o=1 and mux the winner's we/be/addr/wdata onto s_*.
//   - If no request is pending, all s_* outputs are 0.
//   - m_gnt_o[winner] = s_gnt_i, combinational. No other gnt bit is ever high.
//   - On s_gnt_i: owner<=winner, rr_ptr<=winner, state<=WAIT_RSP.
//   - Without s_gnt_i, nothing is latched. Winner is re-evaluated next cycle; a stalled request may lose to none, since rr_ptr is unchanged.
// - WAIT_RSP:
//   - s_req_o=0, s_* data outputs 0, m_gnt_o=0.
//   - On s_rvalid_i: m_rvalid_o[owner]=1 and m_rdata_o lane owner = s_rdata_i (combinational, same cycle); state<=IDLE.
// - Latency: grant in cycle of request (if SRAM idle); response cycle as SRAM provides (1 cycle for behavioural SRAM).
// - Throughput: one request per 2 cycles max, matching the SRAM.
// - Fairness: a continuously requesting port is granted within NUM_PORTS grants.
// - Boundaries:
//   - Simultaneous requests: rotation order from rr_ptr+1.
//   - rr_ptr=NUM_PORTS-1 wraps to port 0.
//   - s_rvalid_i in IDLE is illegal. It is ignored: no m_rvalid_o. Flag with assertion.
//   - Master dropping m_req_i before gnt is allowed (not OBI-compliant, but tolerated). Arbiter re-picks.
//   - Reset mid-transaction: returns to IDLE immediately. The in-flight response is dropped. The SRAM must be reset together with the arbiter; the integrator drives SRAM rst_ni = ~rst_i.
// - Width: owner/rr_ptr are $clog2(NUM_PORTS) bits; modulo computed explicitly for non-power-of-2 NUM_PORTS.
// STRUCTURE
// - gpgpu_obi_pkg: arb_state_t enum {IDLE, WAIT_RSP}; OBI_ADDR_W=32, OBI_DATA_W=32, OBI_BE_W=4.
// - Sub-module obi_rr_pick: combinational; inputs req vector and rr_ptr, outputs winner index and any_req.
// - Top: FSM, owner/rr_ptr registers, request mux, response demux.
// TESTING
// - Reset: rst_i=1 mid-stream -> all outputs 0, state IDLE. After release, ports 0 and 2 request together -> port 0 granted first.
// - Single read: port 1 reads 0x10 preloaded with 0xDEADBEEF -> gnt[1] cycle 0, rvalid[1] cycle 1 with 0xDEADBEEF, other lanes 0.
// - Byte write then read: port 3 writes 0x11223344 be=0b0101 to 0x20, initial data 0 -> port 0 read of 0x20 returns 0x00220044.
// - All 4 ports requesting continuously for 16 cycles -> grant order 0,1,2,3,0,1,2,3; each port granted every 8 cycles.
// - Port 2 alone, then ports 2 and 3 together -> 3 granted before 2 again (rotation past last winner).
// - Random traffic, 10k cycles vs. scoreboard -> data matches, gnt/rvalid one-hot, no rvalid without prior gnt, max wait <= NUM_PORTS grants.

Source files
------------

// File: rtl/gpgpu_obi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gpgpu_obi_pkg
// Description : Shared OBI widths and the arbiter state type for the GPGPU
//               local memory subsystem.
// Revision    : 1.0 - initial release
// ============================================================================
package gpgpu_obi_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = OBI_DATA_W / 8;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } arb_state_t;

endpackage : gpgpu_obi_pkg
`default_nettype wire

// File: rtl/obi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : obi_rr_pick
// Description : Combinational round-robin picker. Searches the request vector
//               starting one past rr_ptr_i, wrapping modulo NUM_PORTS.
// Ports       : req_i     - per-port request vector
//               rr_ptr_i  - index of the most recently granted port
//               winner_o  - index of the selected port (0 when none)
//               any_req_o - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module obi_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic [IDX_W-1:0]     winner_o,
  output logic                 any_req_o
);

  always_comb begin
    int idx;
    idx       = 0;
    winner_o  = '0;
    any_req_o = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      // Explicit wrap so non-power-of-2 port counts rotate correctly.
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      if (!any_req_o && req_i[idx[IDX_W-1:0]]) begin
        winner_o  = idx[IDX_W-1:0];
        any_req_o = 1'b1;
      end
    end
  end

endmodule : obi_rr_pick
`default_nettype wire

// File: rtl/obi_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_sram_arbiter
// Description : Shares one single-port OBI SRAM among NUM_PORTS OBI masters.
//               Round-robin arbitration, one outstanding transaction in total,
//               response routed back to the owning master.
// Ports       : clk_i, rst_i       - clock, async active-high reset
//               m_req_i/we/be/addr/wdata - packed per-master request buses
//               m_gnt_o, m_rvalid_o      - per-master grant / response valid
//               m_rdata_o                - per-master read data lanes
//               s_req_o/we/be/addr/wdata - request towards the SRAM
//               s_gnt_i, s_rvalid_i, s_rdata_i - SRAM handshake and data
// Revision    : 1.0 - initial release
// ============================================================================
module obi_sram_arbiter
  import gpgpu_obi_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = OBI_ADDR_W,
  parameter int DATA_W    = OBI_DATA_W
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            m_req_i,
  input  logic [NUM_PORTS-1:0]            m_we_i,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] m_be_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     m_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]     m_wdata_i,
  output logic [NUM_PORTS-1:0]            m_gnt_o,
  output logic [NUM_PORTS-1:0]            m_rvalid_o,
  output logic [NUM_PORTS*DATA_W-1:0]     m_rdata_o,
  output logic                            s_req_o,
  output logic                            s_we_o,
  output logic [DATA_W/8-1:0]             s_be_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  input  logic                            s_gnt_i,
  input  logic                            s_rvalid_i,
  input  logic [DATA_W-1:0]               s_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [NUM_PORTS-1:0] rvalid_vec;

  logic [BE_W-1:0]   be_arr    [NUM_PORTS];
  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  // Unpack request buses and build the zero-gated response lanes.
  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign be_arr[p]    = m_be_i[p*BE_W +: BE_W];
      assign addr_arr[p]  = m_addr_i[p*ADDR_W +: ADDR_W];
      assign wdata_arr[p] = m_wdata_i[p*DATA_W +: DATA_W];
      assign m_rdata_o[p*DATA_W +: DATA_W] = rvalid_vec[p] ? s_rdata_i : '0;
    end
  endgenerate

  assign m_rvalid_o = rvalid_vec;

  obi_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i     (m_req_i),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Request mux / response demux. Everything is forced low while rst_i is
  // asserted so no master or the SRAM sees activity during reset.
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    rvalid_vec = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            s_req_o          = 1'b1;
            s_we_o           = m_we_i[winner];
            s_be_o           = be_arr[winner];
            s_addr_o         = addr_arr[winner];
            s_wdata_o        = wdata_arr[winner];
            m_gnt_o[winner]  = s_gnt_i;
          end
        end
        WAIT_RSP: begin
          // A response arriving while idle is illegal and simply not routed.
          if (s_rvalid_i) begin
            rvalid_vec[owner_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        // Without a grant nothing is latched; the winner is re-picked.
        if (any_req && s_gnt_i) begin
          owner_d  = winner;
          rr_ptr_d = winner;
          state_d  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (s_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rr_ptr resets to the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= LAST_PORT;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  a_no_rvalid_in_idle : assert property (
    @(posedge clk_i) disable iff (rst_i) !(state_q == IDLE && s_rvalid_i));

  a_gnt_onehot0 : assert property (
    @(posedge clk_i) disable iff (rst_i) $onehot0(m_gnt_o));

endmodule : obi_sram_arbiter
`default_nettype wire

// File: tb/tb_obi_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_sram_arbiter
// Description : Self-checking bench for obi_sram_arbiter: directed scenarios
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_sram_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    m_req, m_we;
  logic [BW-1:0]   be_a    [N];
  logic [AW-1:0]   addr_a  [N];
  logic [DW-1:0]   wdata_a [N];
  logic [N*BW-1:0] m_be;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_gnt, m_rvalid;
  logic [N*DW-1:0] m_rdata;
  logic            s_req, s_we, s_gnt, s_rvalid;
  logic [BW-1:0]   s_be;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;

  generate
    for (genvar p = 0; p < N; p++) begin : g_pack
      assign m_be[p*BW +: BW]    = be_a[p];
      assign m_addr[p*AW +: AW]  = addr_a[p];
      assign m_wdata[p*DW +: DW] = wdata_a[p];
    end
  endgenerate

  obi_sram_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
    .m_rdata_o(m_rdata), .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_gnt_i(s_gnt),
    .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );

  // ---------------- SRAM environment model ----------------
  logic       gnt_en;
  logic [1:0] sram_dly;
  logic [DW-1:0] sram [64];
  logic       pend;
  logic [1:0] cnt;
  logic [DW-1:0] pdat;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h0;
  endfunction

  assign s_gnt = s_req & gnt_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      pend     <= 1'b0;
      cnt      <= '0;
      pdat     <= '0;
      for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
    end else begin
      s_rvalid <= 1'b0;
      s_rdata  <= $urandom;
      if (pend) begin
        if (cnt == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= pdat;
          pend     <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (s_req && s_gnt) begin
        if (sram_dly == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= s_we ? '0 : sram[s_addr[7:2]];
        end else begin
          pend <= 1'b1;
          cnt  <= sram_dly - 1'b1;
          pdat <= s_we ? '0 : sram[s_addr[7:2]];
        end
        if (s_we) begin
          for (int b = 0; b < BW; b++)
            if (s_be[b]) sram[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction-level view: busy flag, owner, last granted port, memory image.
  bit          mdl_busy;
  int          mdl_owner;
  int          mdl_last;
  logic [DW-1:0] mdl_rsp;
  logic [DW-1:0] mdl_mem [64];
  int          wait_cnt [N];
  logic [N-1:0] granted;
  logic [N-1:0] obs_gnt, obs_rvalid;
  logic [N*DW-1:0] obs_rdata;

  task automatic model_and_check();
    logic [N-1:0]    e_gnt, e_rv;
    logic [N*DW-1:0] e_rd;
    logic            e_req, e_we;
    logic [BW-1:0]   e_be;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wd;
    int              w;
    bit              found;
    e_gnt = '0; e_rv = '0; e_rd = '0; e_req = 0; e_we = 0;
    e_be = '0; e_addr = '0; e_wd = '0; w = 0; found = 0;
    granted = '0;
    if (rst) begin
      mdl_busy  = 0;
      mdl_owner = 0;
      mdl_last  = N - 1;
      for (int i = 0; i < 64; i++) mdl_mem[i] = init_word(i);
      for (int p = 0; p < N; p++) wait_cnt[p] = 0;
    end else if (!mdl_busy) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (mdl_last + k) % N;
        if (!found && m_req[p]) begin
          found = 1;
          w = p;
        end
      end
      if (found) begin
        e_req = 1; e_we = m_we[w]; e_be = be_a[w]; e_addr = addr_a[w]; e_wd = wdata_a[w];
        e_gnt[w] = gnt_en;
        if (gnt_en) begin
          mdl_rsp = m_we[w] ? '0 : mdl_mem[addr_a[w][7:2]];
          if (m_we[w])
            for (int b = 0; b < BW; b++)
              if (be_a[w][b]) mdl_mem[addr_a[w][7:2]][8*b +: 8] = wdata_a[w][8*b +: 8];
          for (int p = 0; p < N; p++) begin
            if (p != w && m_req[p]) begin
              wait_cnt[p]++;
              chk("fairness", wait_cnt[p] <= N - 1, 1'b1);
            end else begin
              wait_cnt[p] = 0;
            end
          end
          mdl_busy   = 1;
          mdl_owner  = w;
          mdl_last   = w;
          granted[w] = 1'b1;
        end
      end
    end else if (s_rvalid) begin
      e_rv[mdl_owner] = 1'b1;
      e_rd[mdl_owner*DW +: DW] = mdl_rsp;
      mdl_busy = 0;
    end
    chk("m_gnt", m_gnt, e_gnt);
    chk("m_rvalid", m_rvalid, e_rv);
    chk("m_rdata", m_rdata, e_rd);
    chk("s_req", s_req, e_req);
    chk("s_we", s_we, e_we);
    chk("s_be", s_be, e_be);
    chk("s_addr", s_addr, e_addr);
    chk("s_wdata", s_wdata, e_wd);
  endtask

  // Inputs change #1 after the rising edge; outputs are checked at the falling edge.
  task automatic step();
    @(negedge clk);
    model_and_check();
    obs_gnt    = m_gnt;
    obs_rvalid = m_rvalid;
    obs_rdata  = m_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [BW-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    m_we[p]    = we;
    be_a[p]    = be;
    addr_a[p]  = addr;
    wdata_a[p] = wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ng;
    int gidx;
    int last_g [N];
    bit seen2;

    rst = 1'b1; m_req = '0; m_we = '0; gnt_en = 1'b1; sram_dly = '0;
    for (int p = 0; p < N; p++) set_port(p, 1'b0, '0, '0, '0);
    step();
    step();
    chk("reset_gnt", obs_gnt, '0);
    rst = 1'b0;

    // Single read of preloaded word by port 1
    set_port(1, 1'b0, 4'hF, 32'h10, '0);
    m_req[1] = 1'b1;
    step();
    chk("read_gnt", obs_gnt, 4'b0010);
    m_req[1] = 1'b0;
    step();
    chk("read_rvalid", obs_rvalid, 4'b0010);
    chk("read_rdata", obs_rdata, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

    // Byte-masked write by port 3, read back by port 0
    set_port(3, 1'b1, 4'b0101, 32'h20, 32'h11223344);
    m_req[3] = 1'b1;
    step();
    chk("bw_gnt", obs_gnt, 4'b1000);
    m_req[3] = 1'b0;
    step();
    chk("bw_rvalid", obs_rvalid, 4'b1000);
    set_port(0, 1'b0, 4'hF, 32'h20, '0);
    m_req[0] = 1'b1;
    step();
    chk("bw_rd_gnt", obs_gnt, 4'b0001);
    m_req[0] = 1'b0;
    step();
    chk("bw_rd_data", obs_rdata, {96'h0, 32'h00220044});

    // SRAM stall, requester withdraws, arbiter re-picks
    set_port(1, 1'b0, 4'hF, 32'h4, '0);
    m_req[1] = 1'b1; gnt_en = 1'b0;
    step();
    chk("stall_gnt", obs_gnt, '0);
    m_req[1] = 1'b0; m_req[2] = 1'b1; gnt_en = 1'b1;
    set_port(2, 1'b0, 4'hF, 32'h8, '0);
    step();
    chk("repick_gnt", obs_gnt, 4'b0100);
    m_req[2] = 1'b0;
    step();

    // Reset in the middle of a transaction, then priority from port 0
    m_req[1] = 1'b1;
    step();
    chk("pre_rst_gnt", obs_gnt, 4'b0010);
    m_req[1] = 1'b0;
    rst = 1'b1;
    m_req[0] = 1'b1; m_req[2] = 1'b1;
    set_port(0, 1'b0, 4'hF, 32'h0, '0);
    step();
    chk("rst_mid_gnt", obs_gnt, '0);
    chk("rst_mid_rvalid", obs_rvalid, '0);
    step();
    rst = 1'b0;
    step();
    chk("rst_prio", obs_gnt, 4'b0001);
    m_req[0] = 1'b0;
    step();
    step();
    chk("rst_second", obs_gnt, 4'b0100);
    m_req[2] = 1'b0;
    step();

    // All ports requesting continuously after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 0; p < N; p++) begin
      set_port(p, 1'b0, 4'hF, AW'(p * 4), '0);
      last_g[p] = -1;
    end
    m_req = '1;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (obs_gnt != '0) begin
        gidx = $clog2(int'(obs_gnt));
        chk("rr_order", gidx, ng % N);
        if (last_g[gidx] >= 0) chk("rr_period", c - last_g[gidx], 8);
        last_g[gidx] = c;
        ng++;
      end
    end
    chk("rr_count", ng, 8);
    m_req = '0;
    step();

    // Rotation continues past the last winner
    m_req[2] = 1'b1;
    step();
    chk("alone_gnt", obs_gnt, 4'b0100);
    m_req[2] = 1'b0;
    step();
    m_req[2] = 1'b1; m_req[3] = 1'b1;
    step();
    chk("rot_past", obs_gnt, 4'b1000);
    m_req[3] = 1'b0;
    seen2 = 0;
    for (int c = 0; c < 8 && !seen2; c++) begin
      step();
      if (obs_gnt == 4'b0100) seen2 = 1;
    end
    chk("rot_then2", seen2, 1'b1);
    m_req = '0;
    step();
    step();

    // Randomized traffic
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (m_req[p] && !granted[p]) begin
          if ($urandom_range(15) == 0) m_req[p] = 1'b0;
        end else begin
          m_req[p] = ($urandom_range(1) == 1);
          set_port(p, 1'($urandom_range(1)), 4'($urandom_range(15)),
                   {24'h0, 6'($urandom_range(63)), 2'b00}, $urandom);
        end
      end
      gnt_en   = ($urandom_range(3) != 0);
      sram_dly = ($urandom_range(3) == 0) ? 2'($urandom_range(2, 1)) : 2'd0;
      step();
    end
    m_req = '0; gnt_en = 1'b1; sram_dly = '0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_obi_sram_arbiter
`default_nettype wire
